// File: rtl/gomoku_pkg.sv
// gomoku_pkg: definitions shared by the gomoku board-memory blocks.
//   cell_t      : 2-bit cell state stored in the board RAM.
//   arb_state_t : board_mem_arbiter scheduler state, also exported on dbg_state.
//   cell_addr() : flat cell index row*15+col.
package gomoku_pkg;

  localparam int BOARD_N     = 15;
  localparam int CELL_ADDR_W = 8;
  localparam int BOARD_CELLS = 225;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BLACK = 2'd1,
    WHITE = 2'd2
  } cell_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_PF    = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_t;

  function automatic logic [CELL_ADDR_W-1:0] cell_addr(input logic [3:0] row,
                                                       input logic [3:0] col);
    return ({4'd0, row} * 8'd15) + {4'd0, col};
  endfunction

endpackage

// File: rtl/board_line_buf.sv
// board_line_buf: one board row (15 cells x 2 bits) held in registers.
//   clk, reset_n : clock, asynchronous active-low reset (all cells EMPTY)
//   i_we         : write strobe (prefetch fill or host write-through)
//   i_waddr      : column written, 0..14
//   i_wdata      : cell value written
//   i_raddr      : column read by the pixel path
//   o_rdata      : registered read data (EMPTY for columns >= 15)
module board_line_buf
  import gomoku_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_we,
  input  logic [3:0] i_waddr,
  input  logic [1:0] i_wdata,
  input  logic [3:0] i_raddr,
  output logic [1:0] o_rdata
);

  localparam logic [3:0] L_N = 4'(BOARD_N);

  logic [1:0] r_cells [BOARD_N];
  logic [1:0] r_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BOARD_N; i++) begin
        r_cells[i] <= EMPTY;
      end
      r_rdata <= EMPTY;
    end else begin
      if (i_we && (i_waddr < L_N)) begin
        r_cells[i_waddr] <= i_wdata;
      end
      r_rdata <= (i_raddr < L_N) ? r_cells[i_raddr] : EMPTY;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter: shares the single-port board RAM between the VGA pixel
// path and the game-logic host. At the end of each active line, if the next
// line starts a new cell row, that row is copied into board_line_buf; the
// pixel path reads only that buffer. The host gets the RAM otherwise.
//   clk, reset_n        : clock, asynchronous active-low reset
//   valid, h_cnt, v_cnt : VGA active flag and pixel/line counters
//   pix_cell            : cell under the current pixel (1 clk latency)
//   pix_on_board        : current pixel inside the board (1 clk latency)
//   host_*              : host access port
//   mem_*               : board RAM port (read data 1 clk after mem_en)
//   pf_overrun          : sticky overrun flag, only with
//                         BOARD_MEM_ARB_OVERRUN_EN defined
//   dbg_state           : current scheduler state (arb_state_t)
//
// Host handshake: host_req (with host_we/addr/wdata) is held until host_gnt,
// which pulses for one cycle and is the cycle the RAM op happens; for a read,
// host_rvalid/host_rdata follow exactly one cycle after host_gnt.
module board_mem_arbiter #(
  parameter int BOARD_N = 15,
  parameter int CELL_PX = 32,
  parameter int X0      = 80,
  parameter int Y0      = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       valid,
  input  logic [9:0] h_cnt,
  input  logic [9:0] v_cnt,
  output logic [1:0] pix_cell,
  output logic       pix_on_board,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [7:0] host_addr,
  input  logic [1:0] host_wdata,
  output logic       host_gnt,
  output logic       host_rvalid,
  output logic [1:0] host_rdata,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [1:0] mem_wdata,
  input  logic [1:0] mem_rdata,
`ifdef BOARD_MEM_ARB_OVERRUN_EN
  output logic       pf_overrun,
`endif
  output logic [1:0] dbg_state
);

  import gomoku_pkg::*;

  localparam int         SHIFT      = $clog2(CELL_PX);
  localparam logic [9:0] L_X0       = 10'(X0);
  localparam logic [9:0] L_Y0       = 10'(Y0);
  localparam logic [9:0] L_BOARD_PX = 10'(BOARD_N * CELL_PX);
  localparam logic [9:0] L_V_LAST   = 10'd479;
  localparam logic [3:0] L_COL_LAST = 4'(BOARD_N - 1);
  localparam logic [7:0] L_CELLS    = 8'(BOARD_CELLS);

  arb_state_t r_state, w_state_next;

  logic       r_valid_d;
  logic [9:0] r_last_v;
  logic       r_pf_pending;
  logic [3:0] r_pf_row;
  logic [3:0] r_row;
  logic [3:0] r_col;
  logic       r_cap_en;
  logic [3:0] r_cap_col;
  logic [3:0] r_buf_row;
  logic       r_buf_valid;
  logic       r_rvalid;
  logic       r_roob;
  logic       r_pix_on;
  logic       r_pix_show;

  logic [9:0]  w_next_y;
  logic [10:0] w_ny_off;
  logic        w_next_in;
  logic [3:0]  w_next_row;
  logic        w_trig;
  logic [3:0]  w_start_row;
  logic        w_pf_start;
  logic        w_host_gnt;
  logic        w_host_oob;
  logic [3:0]  w_host_row;
  logic [3:0]  w_host_col;
  logic        w_wt;
  logic        w_mem_en;
  logic        w_mem_we;
  logic [7:0]  w_mem_addr;
  logic [1:0]  w_mem_wdata;
  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic        w_on_board;
  logic [3:0]  w_pcol;
  logic        w_lb_we;
  logic [3:0]  w_lb_waddr;
  logic [1:0]  w_lb_wdata;
  logic [3:0]  w_lb_raddr;
  logic [1:0]  w_lb_rdata;

  // Offsets are taken one bit wider so bit 10 flags "left of / above the
  // board" without any 10-bit subtraction wrapping around.
  assign w_next_y   = (r_last_v == L_V_LAST) ? 10'd0 : r_last_v + 10'd1;
  assign w_ny_off   = {1'b0, w_next_y} - {1'b0, L_Y0};
  assign w_next_in  = !w_ny_off[10] && (w_ny_off[9:0] < L_BOARD_PX);
  assign w_next_row = 4'(w_ny_off[9:0] >> SHIFT);

  // End of an active line whose successor needs a row not already buffered.
  assign w_trig = r_valid_d && !valid && w_next_in &&
                  (!r_buf_valid || (w_next_row != r_buf_row));

  // A fresh trigger carries the most current row; otherwise use the latched one.
  assign w_start_row = w_trig ? w_next_row : r_pf_row;

  assign w_host_oob = (host_addr >= L_CELLS);
  assign w_host_row = 4'(host_addr / 8'd15);
  assign w_host_col = 4'(host_addr % 8'd15);

  always_comb begin
    w_state_next = r_state;
    w_pf_start   = 1'b0;
    w_host_gnt   = 1'b0;
    w_mem_en     = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = '0;
    w_mem_wdata  = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_trig || r_pf_pending) begin
          w_state_next = ARB_PF;
          w_pf_start   = 1'b1;
        end else if (host_req) begin
          w_host_gnt = 1'b1;
          if (!w_host_oob) begin
            w_mem_en    = 1'b1;
            w_mem_we    = host_we;
            w_mem_addr  = host_addr;
            w_mem_wdata = host_we ? host_wdata : 2'd0;
          end
        end
      end
      ARB_PF: begin
        w_mem_en   = 1'b1;
        w_mem_addr = cell_addr(r_row, r_col);
        if (r_col == L_COL_LAST) begin
          w_state_next = ARB_DRAIN;
        end
      end
      ARB_DRAIN: begin
        w_state_next = ARB_IDLE;
      end
      default: begin
        w_state_next = ARB_IDLE;
      end
    endcase
  end

  // Write-through keeps the buffered row coherent with host writes.
  assign w_wt = w_host_gnt && host_we && !w_host_oob && r_buf_valid &&
                (w_host_row == r_buf_row);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ARB_IDLE;
      r_valid_d    <= 1'b0;
      r_last_v     <= '0;
      r_pf_pending <= 1'b0;
      r_pf_row     <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_cap_en     <= 1'b0;
      r_cap_col    <= '0;
      r_buf_row    <= '0;
      r_buf_valid  <= 1'b0;
      r_rvalid     <= 1'b0;
      r_roob       <= 1'b0;
      r_pix_on     <= 1'b0;
      r_pix_show   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_valid_d <= valid;
      if (valid) begin
        r_last_v <= v_cnt;
      end

      // A trigger seen outside IDLE is held until the scheduler can take it.
      if (w_pf_start) begin
        r_pf_pending <= 1'b0;
      end else if (w_trig) begin
        r_pf_pending <= 1'b1;
        r_pf_row     <= w_next_row;
      end

      if (w_pf_start) begin
        r_row       <= w_start_row;
        r_col       <= '0;
        r_buf_valid <= 1'b0;
      end else if (r_state == ARB_PF) begin
        r_col <= r_col + 4'd1;
      end

      if (r_state == ARB_DRAIN) begin
        r_buf_row   <= r_row;
        r_buf_valid <= 1'b1;
      end

      // RAM data for the column issued this cycle lands next cycle.
      r_cap_en  <= (r_state == ARB_PF);
      r_cap_col <= r_col;

      r_rvalid <= w_host_gnt && !host_we;
      r_roob   <= w_host_oob;

      r_pix_on   <= w_on_board;
      r_pix_show <= w_on_board && r_buf_valid;
    end
  end

  assign w_dx       = {1'b0, h_cnt} - {1'b0, L_X0};
  assign w_dy       = {1'b0, v_cnt} - {1'b0, L_Y0};
  assign w_on_board = valid &&
                      !w_dx[10] && (w_dx[9:0] < L_BOARD_PX) &&
                      !w_dy[10] && (w_dy[9:0] < L_BOARD_PX);
  assign w_pcol     = 4'(w_dx[9:0] >> SHIFT);

  // Capture and write-through never coincide: capture only runs in PF/DRAIN,
  // host grants only in IDLE.
  assign w_lb_we    = r_cap_en || w_wt;
  assign w_lb_waddr = r_cap_en ? r_cap_col : w_host_col;
  assign w_lb_wdata = r_cap_en ? mem_rdata : host_wdata;
  assign w_lb_raddr = w_on_board ? w_pcol : 4'd0;

  board_line_buf u_line_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (w_lb_we),
    .i_waddr (w_lb_waddr),
    .i_wdata (w_lb_wdata),
    .i_raddr (w_lb_raddr),
    .o_rdata (w_lb_rdata)
  );

`ifdef BOARD_MEM_ARB_OVERRUN_EN
  logic r_overrun;

  // Next line started before the previous prefetch finished.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (valid && !r_valid_d &&
                 ((r_state != ARB_IDLE) || r_pf_pending)) begin
      r_overrun <= 1'b1;
    end
  end

  assign pf_overrun = r_overrun;
`endif

  assign pix_cell     = r_pix_show ? w_lb_rdata : 2'd0;
  assign pix_on_board = r_pix_on;
  assign host_gnt     = w_host_gnt;
  assign host_rvalid  = r_rvalid;
  assign host_rdata   = (r_rvalid && !r_roob) ? mem_rdata : 2'd0;
  assign mem_en       = w_mem_en;
  assign mem_we       = w_mem_we;
  assign mem_addr     = w_mem_addr;
  assign mem_wdata    = w_mem_wdata;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// tb_board_mem_arbiter: directed bench for board_mem_arbiter with a
// behavioural single-port board RAM. Inputs change on the falling edge;
// combinational outputs are read 1 ns later, registered ones at the
// falling edge after the clock that produced them.
module tb_board_mem_arbiter;
  import gomoku_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       valid = 1'b0;
  logic [9:0] h_cnt = '0;
  logic [9:0] v_cnt = '0;
  logic [1:0] pix_cell;
  logic       pix_on_board;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = '0;
  logic [1:0] host_wdata = '0;
  logic       host_gnt;
  logic       host_rvalid;
  logic [1:0] host_rdata;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata;
  logic [1:0] dbg_state;
`ifdef BOARD_MEM_ARB_OVERRUN_EN
  logic       pf_overrun;
`endif

  board_mem_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid        (valid),
    .h_cnt        (h_cnt),
    .v_cnt        (v_cnt),
    .pix_cell     (pix_cell),
    .pix_on_board (pix_on_board),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_gnt     (host_gnt),
    .host_rvalid  (host_rvalid),
    .host_rdata   (host_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
`ifdef BOARD_MEM_ARB_OVERRUN_EN
    .pf_overrun   (pf_overrun),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------- board RAM model ----------------
  logic [1:0] ram [BOARD_CELLS];
  logic [1:0] ram_q = 2'd0;
  always @(posedge clk) begin
    if (mem_en && (mem_addr < 8'd225)) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_q;

  // ---------------- scoreboard ----------------
  logic [1:0] exp_cell [BOARD_CELLS];
  logic [7:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_video(input logic v, input logic [9:0] h, input logic [9:0] l);
    valid = v;
    h_cnt = h;
    v_cnt = l;
  endtask

  task automatic set_host(input logic req, input logic we, input logic [7:0] a,
                          input logic [1:0] d);
    host_req   = req;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
  endtask

  // One active cycle on line l, then valid drops; returns in the trigger cycle.
  task automatic end_of_line(input logic [9:0] l);
    set_video(1'b1, 10'd100, l);
    tick(1);
    set_video(1'b0, 10'd0, 10'd0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tick(2);
    #1;
    n_cmp++;
    if ({pix_cell, pix_on_board, host_gnt, host_rvalid, host_rdata} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_pix_host: got %b want 0",
               {pix_cell, pix_on_board, host_gnt, host_rvalid, host_rdata});
    end
    n_cmp++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, dbg_state} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_mem_state: got %b want 0",
               {mem_en, mem_we, mem_addr, mem_wdata, dbg_state});
    end
`ifdef BOARD_MEM_ARB_OVERRUN_EN
    n_cmp++;
    if (pf_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_overrun: got %b want 0", pf_overrun);
    end
`endif
    tick(1);
    reset_n = 1'b1;
    tick(1);
    // buffer invalid: every board pixel shows EMPTY
    for (int k = 0; k < 15; k++) begin
      set_video(1'b1, 10'(80 + 32 * k), 10'd5);
      tick(1);
      n_cmp++;
      if (pix_on_board !== 1'b1 || pix_cell !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_pix_col%0d: got on=%b cell=%0d want on=1 cell=0",
                 k, pix_on_board, pix_cell);
      end
    end
    set_video(1'b0, 10'd0, 10'd0);   // falls after line 5 -> row 0 loaded
    tick(20);
  endtask

  task automatic test_prefetch_row1();
    for (int k = 0; k < 15; k++) exp_q.push_back(8'(15 + k));
    end_of_line(10'd31);
    #1;
    n_cmp++;
    if (mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL pf_trigger_cycle: got mem_en=%b want 0", mem_en);
    end
    for (int k = 0; k < 15; k++) begin
      tick(1);
      #1;
      n_cmp++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || exp_q.size() == 0 ||
          mem_addr !== exp_q[0]) begin
        n_fail++;
        $display("FAIL pf_addr_k%0d: got en=%b we=%b addr=%0d want en=1 we=0 addr=%0d",
                 k, mem_en, mem_we, mem_addr, 15 + k);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    tick(1);
    #1;
    n_cmp++;
    if (mem_en !== 1'b0 || dbg_state !== ARB_DRAIN) begin
      n_fail++;
      $display("FAIL pf_drain: got en=%b state=%0d want en=0 state=2", mem_en, dbg_state);
    end
    tick(1);
    #1;
    n_cmp++;
    if (dbg_state !== ARB_IDLE) begin
      n_fail++;
      $display("FAIL pf_back_idle: got state=%0d want 0", dbg_state);
    end
    tick(2);
  endtask

  task automatic test_pixels_and_same_row();
    logic [9:0] hv [4];
    int         hc [4];
    int         n_en;
    for (int k = 0; k < 15; k++) begin
      set_video(1'b1, 10'(80 + 32 * k), 10'd32);
      tick(1);
      n_cmp++;
      if (pix_on_board !== 1'b1 || pix_cell !== exp_cell[15 + k]) begin
        n_fail++;
        $display("FAIL pix_row1_col%0d: got on=%b cell=%0d want on=1 cell=%0d",
                 k, pix_on_board, pix_cell, exp_cell[15 + k]);
      end
    end
    // horizontal edges: column -1 means off board
    hv[0] = 10'd79;  hc[0] = -1;
    hv[1] = 10'd111; hc[1] = 0;
    hv[2] = 10'd559; hc[2] = 14;
    hv[3] = 10'd560; hc[3] = -1;
    for (int i = 0; i < 4; i++) begin
      set_video(1'b1, hv[i], 10'd32);
      tick(1);
      n_cmp++;
      if (pix_on_board !== (hc[i] >= 0) ||
          pix_cell !== ((hc[i] >= 0) ? exp_cell[15 + hc[i]] : 2'd0)) begin
        n_fail++;
        $display("FAIL pix_edge_h%0d: got on=%b cell=%0d", hv[i], pix_on_board, pix_cell);
      end
    end
    set_video(1'b0, 10'd200, 10'd32);
    tick(1);
    n_cmp++;
    if (pix_on_board !== 1'b0 || pix_cell !== 2'd0) begin
      n_fail++;
      $display("FAIL pix_invalid: got on=%b cell=%0d want 0 0", pix_on_board, pix_cell);
    end
    // valid falls after line 32: next line is still row 1
    end_of_line(10'd32);
    n_en = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (mem_en === 1'b1) n_en++;
      tick(1);
    end
    n_cmp++;
    if (n_en != 0) begin
      n_fail++;
      $display("FAIL same_row_no_pf: got %0d mem_en cycles want 0", n_en);
    end
    set_video(1'b1, 10'(80 + 32 * 9), 10'd33);
    tick(1);
    n_cmp++;
    if (pix_cell !== exp_cell[24]) begin
      n_fail++;
      $display("FAIL same_row_buf_kept: got %0d want %0d", pix_cell, exp_cell[24]);
    end
    set_video(1'b0, 10'd0, 10'd0);
    tick(3);
  endtask

  task automatic test_host_during_pf();
    int  waited;
    bit  got;
    end_of_line(10'd63);            // next_y 64 -> row 2
    set_host(1'b1, 1'b1, 8'd17, BLACK);
    waited = 0;
    got = 0;
    #1;
    while (!got && waited < 40) begin
      if (host_gnt === 1'b1) got = 1;
      else begin
        tick(1);
        #1;
        waited++;
      end
    end
    n_cmp++;
    if (!got || waited != 17) begin
      n_fail++;
      $display("FAIL host_wait: got granted=%0d after %0d cycles want 17", got, waited);
    end
    n_cmp++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'd17 || mem_wdata !== BLACK) begin
      n_fail++;
      $display("FAIL host_write_op: got en=%b we=%b addr=%0d d=%0d want 1 1 17 1",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    exp_cell[17] = BLACK;
    tick(1);
    set_host(1'b1, 1'b0, 8'd17, 2'd0);
    #1;
    n_cmp++;
    if (host_gnt !== 1'b1 || host_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL host_read_gnt: got gnt=%b rvalid=%b want 1 0", host_gnt, host_rvalid);
    end
    tick(1);
    set_host(1'b0, 1'b0, 8'd0, 2'd0);
    n_cmp++;
    if (host_rvalid !== 1'b1 || host_rdata !== exp_cell[17]) begin
      n_fail++;
      $display("FAIL host_read_data: got rvalid=%b data=%0d want 1 %0d",
               host_rvalid, host_rdata, exp_cell[17]);
    end
    tick(1);
    n_cmp++;
    if (host_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL host_rvalid_pulse: got %b want 0", host_rvalid);
    end
  endtask

  task automatic test_write_through();
    int n_en;
    end_of_line(10'd31);            // reload row 1 (row 2 was buffered)
    tick(20);
    set_host(1'b1, 1'b1, 8'd20, WHITE);
    #1;
    n_cmp++;
    if (host_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL wt_gnt: got %b want 1", host_gnt);
    end
    exp_cell[20] = WHITE;
    tick(1);
    set_host(1'b0, 1'b0, 8'd0, 2'd0);
    n_en = 0;
    for (int k = 0; k < 15; k++) begin
      set_video(1'b1, 10'(80 + 32 * k), 10'd40);
      #1;
      if (mem_en === 1'b1) n_en++;
      tick(1);
      n_cmp++;
      if (pix_cell !== exp_cell[15 + k]) begin
        n_fail++;
        $display("FAIL wt_pix_col%0d: got %0d want %0d", k, pix_cell, exp_cell[15 + k]);
      end
    end
    n_cmp++;
    if (n_en != 0) begin
      n_fail++;
      $display("FAIL wt_no_reload: got %0d mem_en cycles want 0", n_en);
    end
    set_video(1'b0, 10'd0, 10'd0);
    tick(3);
  endtask

  task automatic test_back_to_back_oob();
    set_host(1'b1, 1'b0, 8'd17, 2'd0);
    #1;
    n_cmp++;
    if (host_gnt !== 1'b1 || mem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first_gnt: got gnt=%b en=%b want 1 1", host_gnt, mem_en);
    end
    tick(1);
    set_host(1'b1, 1'b0, 8'd230, 2'd0);
    #1;
    n_cmp++;
    if (host_gnt !== 1'b1 || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL oob_gnt: got gnt=%b en=%b want 1 0", host_gnt, mem_en);
    end
    n_cmp++;
    if (host_rvalid !== 1'b1 || host_rdata !== exp_cell[17]) begin
      n_fail++;
      $display("FAIL b2b_first_data: got rvalid=%b data=%0d want 1 %0d",
               host_rvalid, host_rdata, exp_cell[17]);
    end
    tick(1);
    set_host(1'b0, 1'b0, 8'd0, 2'd0);
    n_cmp++;
    if (host_rvalid !== 1'b1 || host_rdata !== 2'd0) begin
      n_fail++;
      $display("FAIL oob_data: got rvalid=%b data=%0d want 1 0", host_rvalid, host_rdata);
    end
    tick(2);
  endtask

  task automatic test_wrap();
    end_of_line(10'd479);           // next_y wraps to 0 -> row 0
    for (int k = 0; k < 15; k++) begin
      tick(1);
      #1;
      n_cmp++;
      if (mem_en !== 1'b1 || mem_addr !== 8'(k)) begin
        n_fail++;
        $display("FAIL wrap_addr_k%0d: got en=%b addr=%0d want 1 %0d", k, mem_en, mem_addr, k);
      end
    end
    tick(5);
  endtask

`ifdef BOARD_MEM_ARB_OVERRUN_EN
  task automatic test_overrun();
    n_cmp++;
    if (pf_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_before: got %b want 0", pf_overrun);
    end
    end_of_line(10'd63);
    tick(10);
    set_video(1'b1, 10'd100, 10'd64);
    tick(1);
    n_cmp++;
    if (pf_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_set: got %b want 1", pf_overrun);
    end
    set_video(1'b0, 10'd0, 10'd0);
    tick(40);
    n_cmp++;
    if (pf_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_sticky: got %b want 1", pf_overrun);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (pf_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_reset: got %b want 0", pf_overrun);
    end
    tick(1);
    reset_n = 1'b1;
    tick(2);
  endtask
`endif

  task automatic test_reset_mid_pf();
    end_of_line(10'd31);
    tick(5);
    #1;
    n_cmp++;
    if (mem_en !== 1'b1 || dbg_state !== ARB_PF) begin
      n_fail++;
      $display("FAIL midpf_busy: got en=%b state=%0d want 1 1", mem_en, dbg_state);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_en !== 1'b0 || dbg_state !== ARB_IDLE) begin
      n_fail++;
      $display("FAIL midpf_abort: got en=%b state=%0d want 0 0", mem_en, dbg_state);
    end
    tick(1);
    reset_n = 1'b1;
    tick(1);
    set_video(1'b1, 10'(80 + 32 * 3), 10'd40);
    tick(1);
    n_cmp++;
    if (pix_on_board !== 1'b1 || pix_cell !== 2'd0) begin
      n_fail++;
      $display("FAIL midpf_buf_invalid: got on=%b cell=%0d want 1 0", pix_on_board, pix_cell);
    end
    set_video(1'b0, 10'd0, 10'd0);
    tick(20);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < BOARD_CELLS; i++) begin
      ram[i]      = 2'((i + 1) % 3);
      exp_cell[i] = 2'((i + 1) % 3);
    end
    test_reset();
    test_prefetch_row1();
    test_pixels_and_same_row();
    test_host_during_pf();
    test_write_through();
    test_back_to_back_oob();
    test_wrap();
`ifdef BOARD_MEM_ARB_OVERRUN_EN
    test_overrun();
`endif
    test_reset_mid_pf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/board_mem_arbiter.md
# board_mem_arbiter

Schedules the single-port board-state RAM (15×15 gomoku cells, 2 bits each) between the display path and the game-logic host. Driven by the VGA timing controller's `valid`/`h_cnt`/`v_cnt`: at the end of each active line, if the next line enters a new cell row, it prefetches that row into a 15-entry line buffer. The pixel path is served only from this buffer, never from RAM. Host reads and writes use the RAM in the remaining cycles.

## Interface
- `BOARD_N`, 15: cells per side.
- `CELL_PX`, 32: cell size in pixels, power of two.
- `X0`, 80: left board edge (pixels).
- `Y0`, 0: top board edge (lines).
- `clk` in 1: system clock. One clock domain.
- `reset_n` in 1: reset, asynchronous, active-low.
- `valid` in 1: active-video flag from the VGA controller.
- `h_cnt` in 10: pixel column, 0 outside active video.
- `v_cnt` in 10: line number, 0 outside active video.
- `pix_cell` out 2: cell state at the current pixel, registered.
- `pix_on_board` out 1: current pixel lies inside the board, registered.
- `host_req` in 1: host access request; held until granted.
- `host_we` in 1: 1 = write, 0 = read.
- `host_addr` in 8: cell index, row*15+col.
- `host_wdata` in 2: write data.
- `host_gnt` out 1: one-cycle grant pulse.
- `host_rvalid` out 1: read data valid, exactly 1 cycle after a read `host_gnt`.
- `host_rdata` out 2: read data.
- `mem_en`, `mem_we` out 1 each: RAM strobes.
- `mem_addr` out 8, `mem_wdata` out 2: RAM address and write data.
- `mem_rdata` in 2: RAM read data, valid 1 cycle after `mem_en` with `!mem_we`.
- `pf_overrun` out 1: sticky overrun flag. Exists only with `BOARD_MEM_ARB_OVERRUN_EN`.

## Operation
- FSM states:
  - IDLE: host may be granted.
  - PF: issues the reads for col 0..14, one per cycle.
  - DRAIN: captures the col-14 data, then returns to IDLE.
- Trigger: registered `valid_d & ~valid` (end of active line).
  - `last_v` captures `v_cnt` while `valid` is high.
  - `next_y = last_v+1`, wrapping 479→0.
  - Prefetch only if `next_y` is in `[Y0, Y0+BOARD_N*CELL_PX)` and `row = (next_y-Y0)>>log2(CELL_PX)` differs from `buf_row`, or `buf_valid` is 0.
  - Otherwise no RAM activity.
- Trigger priority and holding:
  - A trigger is latched as `pf_pending` and taken from IDLE ahead of any host request.
  - A trigger arriving during a host grant cycle starts PF on the next cycle.
- PF/DRAIN RAM traffic:
  - `mem_addr = row*15 + col`.
  - Returned data is written to `buf[col-1]` the following cycle.
  - On DRAIN exit: `buf_row` ← row, `buf_valid` ← 1.
- Host access:
  - Granted in IDLE when `pf_pending` is 0.
  - `host_gnt` and the RAM op occur in the same cycle.
  - Writes: `mem_we = 1`.
  - Reads: `host_rdata`/`host_rvalid` appear the next cycle.
  - Back-to-back grants are allowed every cycle.
- Out-of-range address (`host_addr >= 225`): granted, but no RAM op; a read returns 0 with `host_rvalid`.
- Write-through: a host write whose row equals `buf_row` (with `buf_valid` set) also updates `buf[col]` in the same cycle.
- Pixel path:
  - `col = (h_cnt-X0)>>log2(CELL_PX)`.
  - `pix_on_board = valid && X0 <= h_cnt < X0+480 && Y0 <= v_cnt < Y0+480`.
  - `pix_cell = buf[col]` if on board and `buf_valid`, else 0 (EMPTY).
- Arithmetic is 10-bit unsigned; compare before subtracting so nothing underflows.

## Timing
- Reset values:
  - All outputs 0.
  - FSM IDLE, `buf_valid` 0, `buf` all EMPTY, `pf_pending` 0.
  - `valid_d` 0 and `last_v` 0.
- Prefetch timing:
  - Valid falls at cycle T (`valid` 0 sampled in T, `valid_d` 1): PF issues col 0 at T+1 and col 14 at T+15.
  - DRAIN at T+16; IDLE at T+17.
  - Busy for 16 cycles, well inside the 640-clk hblank.
- Pixel output latency: 1 clk from `h_cnt`/`v_cnt`/`valid`.
- Host read latency: `host_gnt` at cycle G → `host_rvalid` at G+1.
- Worst-case host wait: 17 cycles (full prefetch plus one cycle).
- Reset asserted mid-PF: aborts immediately and returns to reset values; partially filled buffer is invalidated.

## Configuration
- `BOARD_MEM_ARB_OVERRUN_EN` defined:
  - `pf_overrun` port exists.
  - It is set when `valid` rises while the FSM is not IDLE or `pf_pending` is 1.
  - It is cleared only by reset.
- Undefined: port and logic are absent; behaviour is otherwise identical.

## Structure
- Shared package `gomoku_pkg`:
  - `cell_t` enum: EMPTY=0, BLACK=1, WHITE=2.
  - `BOARD_N`, `CELL_ADDR_W=8`, `BOARD_CELLS=225`.
  - FSM state enum `arb_state_t`.
- Sub-module `board_line_buf`: 15×2-bit register file with one write port (prefetch or write-through, write-through never concurrent with prefetch) and a registered read port for the pixel path.

## Test plan
- Reset, idle video → all outputs 0, `pix_cell`=0 on all board pixels.
- `valid` falls after line 31 (`next_y`=32, row 1) → `mem_addr` 15..29 on 15 consecutive cycles; then pixels at `h_cnt`=80+32k on line 32 return the preloaded `cell[15+k]`.
- `valid` falls after line 32 (same row) → no `mem_en` and buffer unchanged.
- `host_req` write, addr 17, BLACK, asserted at T (the prefetch trigger cycle) → `host_gnt` at T+17; a later read of 17 returns 1 with `host_rvalid` one cycle after its grant.
- Row 1 buffered, host write addr 20 = WHITE → `pix_cell`=2 at `h_cnt`=240 on the next line without a re-prefetch.
- Host read addr 230 → `host_gnt`, no `mem_en`, `host_rdata`=0; with the macro defined, `valid` rising 10 cycles after the trigger → `pf_overrun`=1 and it stays 1 until `reset_n` is asserted.
